// File: rtl/muldiv_alu_sequencer_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer that borrows the execute ALU.
package muldiv_alu_sequencer_pkg;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MUL   = 2'b00,
        MULHU = 2'b01,
        DIVU  = 2'b10,
        REMU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

    // MULHU and REMU read the upper/remainder register; MUL and DIVU read the lower/quotient one.
    function automatic logic result_from_hi(muldiv_op_e op);
        return (op == MULHU) || (op == REMU);
    endfunction

endpackage

// File: rtl/muldiv_alu_sequencer_if.sv
// Request/response and shared-ALU handshake bundle between EX and the muldiv sequencer.
interface muldiv_alu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;

    logic            alu_req;
    logic            alu_gnt;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            alu_carry;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_gnt, alu_result, alu_carry,
        input  req_ready, rsp_valid, rsp_result, alu_req, alu_a, alu_b, alu_ctrl
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_gnt, alu_result, alu_carry,
        output req_ready, rsp_valid, rsp_result, alu_req, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/muldiv_alu_sequencer.sv
// Shift-add multiply and restoring divide, one shared-ALU add/sub per granted cycle.
module muldiv_alu_sequencer
    import muldiv_alu_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    output logic                 busy,
    muldiv_alu_sequencer_if.slave bus
);

    localparam int CW = $clog2(XLEN);

    seq_state_e      state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            is_div;
    logic            step;
    logic            quot_bit;
    logic [XLEN-1:0] div_shift;

    assign is_div    = op_q[1];
    assign step      = (state_q == RUN) && bus.alu_gnt;
    assign div_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    // A remainder msb shifted out means the partial remainder already exceeds any divisor.
    assign quot_bit  = hi_q[XLEN-1] | bus.alu_carry;

    assign busy           = (state_q != IDLE);
    assign bus.req_ready  = (state_q == IDLE) && !flush;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.alu_req    = (state_q == RUN);
    assign bus.rsp_result = result_from_hi(op_q) ? hi_q : lo_q;

    always_comb begin
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = ADD;
        if (state_q == RUN) begin
            if (is_div) begin
                bus.alu_a    = div_shift;
                bus.alu_b    = opnd_q;
                bus.alu_ctrl = SUB;
            end else begin
                bus.alu_a    = hi_q;
                bus.alu_b    = lo_q[0] ? opnd_q : '0;
                bus.alu_ctrl = ADD;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && !flush) begin
                    op_d   = muldiv_op_e'(bus.req_op);
                    opnd_d = bus.req_b;
                    // Divide by zero skips the loop: quotient all-ones, remainder = dividend.
                    if (bus.req_op[1] && (bus.req_b == '0)) begin
                        hi_d    = bus.req_a;
                        lo_d    = '1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = bus.req_a;
                        cnt_d   = CW'(XLEN - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (step) begin
                    if (is_div) begin
                        hi_d = quot_bit ? bus.alu_result : div_shift;
                        lo_d = {lo_q[XLEN-2:0], quot_bit};
                    end else begin
                        {hi_d, lo_d} = {bus.alu_carry, bus.alu_result, lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (flush || bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
